inst_buffer: RTL and testbench

Front-end instruction buffer between the fetch stage (PC register plus instruction-cache response) and dual-issue decode. It accepts at most one fetched instruction per cycle with its PC and exception tags, holds the instructions in a circular FIFO, and presents up to two oldest entries to decode each cycle. It generates the `stall` that holds the PC register when space runs low, and it empties completely on any pipeline flush.

---
 rtl/inst_buffer_pkg.sv | 30 +++
 rtl/inst_buffer.sv | 68 ++++++
 tb/tb_inst_buffer.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_buffer_pkg.sv
// Shared types for the fetch-to-decode instruction buffer: the buffered entry
// layout and the 7-bit exception cause codes carried in its tags.
package inst_buffer_pkg;

  localparam int IB_DEPTH_DEFAULT = 8;
  localparam int EXC_SLOTS        = 6;
  localparam int EXC_CODE_W       = 7;

  // Cause codes, matching csr_define.sv
  localparam logic [EXC_CODE_W-1:0] EXC_INT  = 7'h00;
  localparam logic [EXC_CODE_W-1:0] EXC_PIL  = 7'h01;
  localparam logic [EXC_CODE_W-1:0] EXC_PIS  = 7'h02;
  localparam logic [EXC_CODE_W-1:0] EXC_PIF  = 7'h03;
  localparam logic [EXC_CODE_W-1:0] EXC_PME  = 7'h04;
  localparam logic [EXC_CODE_W-1:0] EXC_PPI  = 7'h07;
  localparam logic [EXC_CODE_W-1:0] EXC_ADEF = 7'h08;
  localparam logic [EXC_CODE_W-1:0] EXC_ALE  = 7'h09;
  localparam logic [EXC_CODE_W-1:0] EXC_SYS  = 7'h0b;
  localparam logic [EXC_CODE_W-1:0] EXC_BRK  = 7'h0c;
  localparam logic [EXC_CODE_W-1:0] EXC_INE  = 7'h0d;
  localparam logic [EXC_CODE_W-1:0] EXC_TLBR = 7'h3f;

  typedef struct packed {
    logic [31:0]                                pc;
    logic [31:0]                                inst;
    logic [EXC_SLOTS-1:0]                       is_exception;
    logic [EXC_SLOTS-1:0][EXC_CODE_W-1:0]       exception_cause;
  } inst_buffer_entry_t;

endpackage

// File: rtl/inst_buffer.sv
// Circular instruction FIFO between fetch and dual-issue decode: one push per
// cycle, up to two in-order pops per cycle, early stall, and full flush.
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH = IB_DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       fetch_valid,
  input  inst_buffer_entry_t         fetch_entry,
  input  logic                       dec_ready_1,
  input  logic                       dec_ready_2,
  output logic                       dec_valid_1,
  output logic                       dec_valid_2,
  output inst_buffer_entry_t         dec_entry_1,
  output inst_buffer_entry_t         dec_entry_2,
  output logic                       stall,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  inst_buffer_entry_t mem [DEPTH];
  logic [PW-1:0]      head;
  logic [PW-1:0]      tail;
  logic [PW-1:0]      head_p1;
  logic               push;
  logic               pop1;
  logic               pop2;
  logic               clear;

  // Handshake: an entry transfers to decode slot N in a cycle where
  // dec_valid_N and dec_ready_N are both high; slot 2 transfers only when
  // slot 1 also transfers, so decode always receives entries in program order.
  always_comb begin
    clear       = rst | flush;
    head_p1     = head + PW'(1);
    dec_valid_1 = (count >= CW'(1)) && !clear;
    dec_valid_2 = (count >= CW'(2)) && !clear;
    dec_entry_1 = mem[head];
    dec_entry_2 = mem[head_p1];
    pop1        = dec_valid_1 & dec_ready_1;
    pop2        = pop1 & dec_valid_2 & dec_ready_2;
    // A full buffer refuses the push even if decode drains an entry this cycle.
    push        = fetch_valid && (count < CW'(DEPTH)) && !clear;
    stall       = count >= CW'(DEPTH - 2);
  end

  // Entry contents are deliberately left untouched on clear.
  always_ff @(posedge clk) begin
    if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[tail] <= fetch_entry;
        tail      <= tail + PW'(1);
      end
      head  <= head + PW'(pop1) + PW'(pop2);
      count <= count + CW'(push) - CW'(pop1) - CW'(pop2);
    end
  end

endmodule

// File: tb/tb_inst_buffer.sv
// Directed bench for inst_buffer: ordering, stall threshold, flush, reset,
// wrap-around streaming and exception-tag pass-through.
module tb_inst_buffer;
  import inst_buffer_pkg::*;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic               clk;
  logic               rst;
  logic               flush;
  logic               fetch_valid;
  inst_buffer_entry_t fetch_entry;
  logic               dec_ready_1;
  logic               dec_ready_2;
  logic               dec_valid_1;
  logic               dec_valid_2;
  inst_buffer_entry_t dec_entry_1;
  inst_buffer_entry_t dec_entry_2;
  logic               stall;
  logic [CW-1:0]      count;

  int n_checks;
  int n_fail;
  int drop_cnt;
  logic [31:0] exp_q[$];

  inst_buffer #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .fetch_valid (fetch_valid),
    .fetch_entry (fetch_entry),
    .dec_ready_1 (dec_ready_1),
    .dec_ready_2 (dec_ready_2),
    .dec_valid_1 (dec_valid_1),
    .dec_valid_2 (dec_valid_2),
    .dec_entry_1 (dec_entry_1),
    .dec_entry_2 (dec_entry_2),
    .stall       (stall),
    .count       (count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A fetch arriving while full would be silently dropped.
  always @(posedge clk) begin
    if (!rst && !flush && fetch_valid && count == CW'(DEPTH)) begin
      drop_cnt = drop_cnt + 1;
      $display("FAIL drop_while_full: fetch pc=%h arrived with count=%0d, required count<%0d",
               fetch_entry.pc, count, DEPTH);
    end
  end

  function automatic inst_buffer_entry_t mk(input logic [31:0] pc);
    inst_buffer_entry_t e;
    e                 = '0;
    e.pc              = pc;
    e.inst            = pc ^ 32'hdead_0000;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    flush       = 1'b0;
    fetch_valid = 1'b0;
    fetch_entry = '0;
    dec_ready_1 = 1'b0;
    dec_ready_2 = 1'b0;
    step();
    step();
    rst = 1'b0;
    settle();
  endtask

  task automatic push_n(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      fetch_valid = 1'b1;
      fetch_entry = mk(base + 32'(4 * i));
      step();
    end
    fetch_valid = 1'b0;
    settle();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d, required 0", count); end
    n_checks++; if (dec_valid_1 !== 1'b0) begin n_fail++; $display("FAIL reset_valid1: got %b, required 0", dec_valid_1); end
    n_checks++; if (dec_valid_2 !== 1'b0) begin n_fail++; $display("FAIL reset_valid2: got %b, required 0", dec_valid_2); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b, required 0", stall); end
  endtask

  task automatic test_basic();
    do_reset();
    push_n(32'h100, 3);
    n_checks++; if (count !== 4'd3) begin n_fail++; $display("FAIL basic_count3: got %0d, required 3", count); end
    n_checks++; if (dec_valid_1 !== 1'b1 || dec_valid_2 !== 1'b1) begin n_fail++; $display("FAIL basic_valids: got %b%b, required 11", dec_valid_1, dec_valid_2); end
    n_checks++; if (dec_entry_1.pc !== 32'h100) begin n_fail++; $display("FAIL basic_entry1: got %h, required 00000100", dec_entry_1.pc); end
    n_checks++; if (dec_entry_2.pc !== 32'h104) begin n_fail++; $display("FAIL basic_entry2: got %h, required 00000104", dec_entry_2.pc); end
    n_checks++; if (dec_entry_2.inst !== 32'hdead_0104) begin n_fail++; $display("FAIL basic_inst2: got %h, required dead0104", dec_entry_2.inst); end
    dec_ready_1 = 1'b1;
    dec_ready_2 = 1'b1;
    step();
    dec_ready_1 = 1'b0;
    dec_ready_2 = 1'b0;
    settle();
    n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL basic_count1: got %0d, required 1", count); end
    n_checks++; if (dec_entry_1.pc !== 32'h108) begin n_fail++; $display("FAIL basic_head_after_pop: got %h, required 00000108", dec_entry_1.pc); end
    n_checks++; if (dec_valid_2 !== 1'b0) begin n_fail++; $display("FAIL basic_valid2_low: got %b, required 0", dec_valid_2); end
  endtask

  task automatic test_stall();
    do_reset();
    push_n(32'h1000, 5);
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL stall_at5: got %b, required 0", stall); end
    push_n(32'h1014, 1);
    n_checks++; if (count !== 4'd6 || stall !== 1'b1) begin n_fail++; $display("FAIL stall_at6: got count=%0d stall=%b, required 6/1", count, stall); end
    push_n(32'h1018, 1);
    n_checks++; if (count !== 4'd7 || stall !== 1'b1) begin n_fail++; $display("FAIL stall_inflight: got count=%0d stall=%b, required 7/1", count, stall); end
    n_checks++; if (drop_cnt !== 0) begin n_fail++; $display("FAIL stall_no_drop: got %0d drops, required 0", drop_cnt); end
    push_n(32'h101c, 1);
    n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL stall_full: got %0d, required 8", count); end
  endtask

  task automatic test_slot2_only();
    do_reset();
    push_n(32'h2000, 4);
    dec_ready_1 = 1'b0;
    dec_ready_2 = 1'b1;
    step();
    settle();
    n_checks++; if (count !== 4'd4) begin n_fail++; $display("FAIL slot2_only_count: got %0d, required 4", count); end
    n_checks++; if (dec_entry_1.pc !== 32'h2000) begin n_fail++; $display("FAIL slot2_only_head: got %h, required 00002000", dec_entry_1.pc); end
    dec_ready_2 = 1'b0;
  endtask

  task automatic test_simul_push_pop();
    do_reset();
    push_n(32'h3000, 1);
    n_checks++; if (dec_valid_1 !== 1'b1) begin n_fail++; $display("FAIL simul_valid1: got %b, required 1", dec_valid_1); end
    fetch_valid = 1'b1;
    fetch_entry = mk(32'h3004);
    dec_ready_1 = 1'b1;
    step();
    fetch_valid = 1'b0;
    dec_ready_1 = 1'b0;
    settle();
    n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL simul_count: got %0d, required 1", count); end
    n_checks++; if (dec_entry_1.pc !== 32'h3004) begin n_fail++; $display("FAIL simul_head: got %h, required 00003004", dec_entry_1.pc); end
  endtask

  task automatic test_wrap_stream();
    logic [31:0] pc;
    int pops;
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back(32'h4000 + 32'(4 * i));
    push_n(32'h4000, 3);
    pc = 32'h400c;
    pops = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      fetch_valid = (cyc < 20);
      fetch_entry = mk(pc);
      dec_ready_1 = 1'b1;
      dec_ready_2 = 1'b1;
      settle();
      if (dec_valid_1) begin
        n_checks++;
        if (exp_q.size() == 0 || dec_entry_1.pc !== exp_q[0]) begin
          n_fail++; $display("FAIL wrap_slot1: got %h, required %h", dec_entry_1.pc, (exp_q.size() == 0) ? 32'hx : exp_q[0]);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        pops++;
        if (dec_valid_2) begin
          n_checks++;
          if (exp_q.size() == 0 || dec_entry_2.pc !== exp_q[0]) begin
            n_fail++; $display("FAIL wrap_slot2: got %h, required %h", dec_entry_2.pc, (exp_q.size() == 0) ? 32'hx : exp_q[0]);
          end
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          pops++;
        end
      end
      if (fetch_valid) begin
        exp_q.push_back(pc);
        pc = pc + 32'd4;
      end
      step();
    end
    fetch_valid = 1'b0;
    dec_ready_1 = 1'b0;
    dec_ready_2 = 1'b0;
    settle();
    n_checks++; if (exp_q.size() != 0 || pops != 23) begin n_fail++; $display("FAIL wrap_drained: got %0d left, %0d popped, required 0 left, 23 popped", exp_q.size(), pops); end
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL wrap_count: got %0d, required 0", count); end
  endtask

  task automatic test_flush();
    do_reset();
    push_n(32'h5000, 5);
    flush       = 1'b1;
    fetch_valid = 1'b1;
    fetch_entry = mk(32'h200);
    dec_ready_1 = 1'b1;
    dec_ready_2 = 1'b1;
    settle();
    n_checks++; if (dec_valid_1 !== 1'b0 || dec_valid_2 !== 1'b0) begin n_fail++; $display("FAIL flush_valids: got %b%b, required 00", dec_valid_1, dec_valid_2); end
    step();
    flush       = 1'b0;
    fetch_valid = 1'b0;
    settle();
    n_checks++; if (count !== 4'd0 || dec_valid_1 !== 1'b0) begin n_fail++; $display("FAIL flush_empty: got count=%0d v1=%b, required 0/0", count, dec_valid_1); end
    push_n(32'h400, 1);
    n_checks++; if (count !== 4'd1 || dec_entry_1.pc !== 32'h400) begin n_fail++; $display("FAIL flush_discard: got count=%0d pc=%h, required 1/00000400", count, dec_entry_1.pc); end
    dec_ready_1 = 1'b0;
    dec_ready_2 = 1'b0;
  endtask

  task automatic test_rst_mid();
    do_reset();
    push_n(32'h6000, 3);
    rst         = 1'b1;
    fetch_valid = 1'b1;
    fetch_entry = mk(32'h6100);
    dec_ready_1 = 1'b1;
    settle();
    n_checks++; if (dec_valid_1 !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b, required 0", dec_valid_1); end
    step();
    rst         = 1'b0;
    fetch_valid = 1'b0;
    dec_ready_1 = 1'b0;
    settle();
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL rst_mid_count: got %0d, required 0", count); end
  endtask

  task automatic test_exception();
    inst_buffer_entry_t e;
    do_reset();
    e                    = mk(32'h7000_0003);
    e.is_exception       = 6'b010000;
    e.exception_cause[4] = EXC_ADEF;
    e.exception_cause[0] = EXC_INT;
    e.exception_cause[5] = 7'h55;
    fetch_valid = 1'b1;
    fetch_entry = e;
    settle();
    n_checks++; if (dec_valid_1 !== 1'b0) begin n_fail++; $display("FAIL exc_no_bypass: got %b, required 0", dec_valid_1); end
    step();
    fetch_valid = 1'b0;
    settle();
    n_checks++; if (dec_valid_1 !== 1'b1 || dec_entry_1 !== e) begin n_fail++; $display("FAIL exc_passthrough: got v=%b %h, required 1 %h", dec_valid_1, dec_entry_1, e); end
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    drop_cnt    = 0;
    rst         = 1'b1;
    flush       = 1'b0;
    fetch_valid = 1'b0;
    fetch_entry = '0;
    dec_ready_1 = 1'b0;
    dec_ready_2 = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_slot2_only();
    test_simul_push_pop();
    test_wrap_stream();
    test_flush();
    test_rst_mid();
    test_exception();
    n_checks++; if (drop_cnt !== 0) begin n_fail++; $display("FAIL no_drops_overall: got %0d, required 0", drop_cnt); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
